// File: rtl/isp_program_loader.sv
// Byte-stream program loader: frames MAGIC/length/data/checksum into 32-bit ISP writes,
// then releases the core from reset and pulses start on a good checksum.
module isp_program_loader #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDRESS_BITS = 12,
  parameter logic [19:0] PROG_ADDRESS = 20'h00000,
  parameter logic [7:0]  MAGIC        = 8'hA5,
  parameter logic [15:0] TIMEOUT      = 16'd50000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    isp_write,
  output logic [ADDRESS_BITS-1:0] isp_address,
  output logic [DATA_WIDTH-1:0]   isp_data,
  output logic                    core_reset,
  output logic                    start,
  output logic [19:0]             prog_address,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  typedef enum logic [2:0] {StIdle, StLenLo, StLenHi, StData, StCheck} state_e;

  // One extra bit so a full 2**ADDRESS_BITS word count is representable.
  localparam int unsigned CntW     = ADDRESS_BITS + 1;
  localparam logic [31:0] MaxWords = 32'd1 << ADDRESS_BITS;

  state_e                  state_q, state_d;
  logic [7:0]              len_lo_q, len_lo_d;
  logic [CntW-1:0]         word_total_q, word_total_d;
  logic [CntW-1:0]         wr_cnt_q, wr_cnt_d;
  logic [1:0]              byte_cnt_q, byte_cnt_d;
  logic [DATA_WIDTH-9:0]   word_q, word_d;
  logic [7:0]              chk_q, chk_d;
  logic [15:0]             timeout_q, timeout_d;
  logic                    isp_write_q, isp_write_d;
  logic [ADDRESS_BITS-1:0] isp_address_q, isp_address_d;
  logic [DATA_WIDTH-1:0]   isp_data_q, isp_data_d;
  logic                    core_reset_q, core_reset_d;
  logic                    start_q, start_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;

  logic [15:0] len_n;
  logic        len_bad;
  logic        timeout_hit;
  logic        last_word;
  logic        is_magic;

  assign len_n       = {rx_data, len_lo_q};
  assign len_bad     = 32'(len_n) > MaxWords;
  assign timeout_hit = (state_q != StIdle) && !rx_valid && (timeout_q == TIMEOUT - 16'd1);
  assign last_word   = (wr_cnt_q + CntW'(1)) == word_total_q;
  assign is_magic    = rx_valid && (rx_data == MAGIC);

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      len_lo_q      <= '0;
      word_total_q  <= '0;
      wr_cnt_q      <= '0;
      byte_cnt_q    <= '0;
      word_q        <= '0;
      chk_q         <= '0;
      timeout_q     <= '0;
      isp_write_q   <= 1'b0;
      isp_address_q <= '0;
      isp_data_q    <= '0;
      core_reset_q  <= 1'b1;
      start_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_lo_q      <= len_lo_d;
      word_total_q  <= word_total_d;
      wr_cnt_q      <= wr_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      word_q        <= word_d;
      chk_q         <= chk_d;
      timeout_q     <= timeout_d;
      isp_write_q   <= isp_write_d;
      isp_address_q <= isp_address_d;
      isp_data_q    <= isp_data_d;
      core_reset_q  <= core_reset_d;
      start_q       <= start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (is_magic) state_d = StLenLo;
      end
      StLenLo: begin
        if (timeout_hit)   state_d = StIdle;
        else if (rx_valid) state_d = StLenHi;
      end
      StLenHi: begin
        if (timeout_hit) begin
          state_d = StIdle;
        end else if (rx_valid) begin
          if (len_bad)             state_d = StIdle;
          else if (len_n == '0)    state_d = StCheck;
          else                     state_d = StData;
        end
      end
      StData: begin
        if (timeout_hit)                                     state_d = StIdle;
        else if (rx_valid && (byte_cnt_q == 2'd3) && last_word) state_d = StCheck;
      end
      StCheck: begin
        if (timeout_hit || rx_valid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    len_lo_d      = len_lo_q;
    word_total_d  = word_total_q;
    wr_cnt_d      = wr_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    word_d        = word_q;
    chk_d         = chk_q;
    timeout_d     = timeout_q;
    isp_write_d   = 1'b0;
    isp_address_d = isp_address_q;
    isp_data_d    = isp_data_q;
    core_reset_d  = core_reset_q;
    start_d       = 1'b0;
    busy_d        = busy_q;
    done_d        = done_q;
    error_d       = error_q;

    if (state_q != StIdle) begin
      timeout_d = rx_valid ? 16'd0 : timeout_q + 16'd1;
      if (rx_valid) chk_d = chk_q ^ rx_data;
    end

    if (timeout_hit) begin
      error_d = 1'b1;
      busy_d  = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (is_magic) begin
          done_d       = 1'b0;
          error_d      = 1'b0;
          busy_d       = 1'b1;
          core_reset_d = 1'b1;
          wr_cnt_d     = '0;
          chk_d        = '0;
          timeout_d    = '0;
          byte_cnt_d   = '0;
        end
      end
      StLenLo: begin
        if (rx_valid) len_lo_d = rx_data;
      end
      StLenHi: begin
        if (rx_valid) begin
          word_total_d = CntW'(len_n);
          if (len_bad) begin
            error_d = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      StData: begin
        if (rx_valid) begin
          word_d     = {rx_data, word_q[DATA_WIDTH-9:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            isp_write_d   = 1'b1;
            isp_address_d = wr_cnt_q[ADDRESS_BITS-1:0];
            isp_data_d    = {rx_data, word_q};
            wr_cnt_d      = wr_cnt_q + CntW'(1);
          end
        end
      end
      StCheck: begin
        if (rx_valid) begin
          busy_d = 1'b0;
          if (rx_data == chk_q) begin
            done_d       = 1'b1;
            core_reset_d = 1'b0;
            start_d      = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign isp_write    = isp_write_q;
  assign isp_address  = isp_address_q;
  assign isp_data     = isp_data_q;
  assign core_reset   = core_reset_q;
  assign start        = start_q;
  assign prog_address = PROG_ADDRESS;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_isp_program_loader.sv
// Randomised scoreboard bench for isp_program_loader: a frame generator pushes expected
// writes/outcomes, and a negedge monitor pops and compares as the DUT produces them.
module tb_isp_program_loader;

  localparam int unsigned TB_TIMEOUT = 20;
  localparam int unsigned AB         = 12;
  localparam logic [19:0] PROG       = 20'h00000;
  localparam logic [7:0]  MAG        = 8'hA5;
  localparam int KWrite = 0, KDone = 1, KError = 2;

  typedef struct {
    int          kind;
    logic [11:0] addr;
    logic [31:0] data;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          isp_write;
  logic [AB-1:0] isp_address;
  logic [31:0]   isp_data;
  logic          core_reset;
  logic          start;
  logic [19:0]   prog_address;
  logic          busy;
  logic          done;
  logic          error;

  isp_program_loader #(
    .DATA_WIDTH  (32),
    .ADDRESS_BITS(AB),
    .PROG_ADDRESS(PROG),
    .MAGIC       (MAG),
    .TIMEOUT     (16'(TB_TIMEOUT))
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .isp_write   (isp_write),
    .isp_address (isp_address),
    .isp_data    (isp_data),
    .core_reset  (core_reset),
    .start       (start),
    .prog_address(prog_address),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_pass   = 0;
  exp_t        exp_q[$];
  logic [31:0] frame_words[$];
  logic        mon_en = 1'b0;
  logic        start_prev = 1'b0, error_prev = 1'b0;
  exp_t        mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
  endtask

  task automatic push(input int kind, input int addr, input logic [31:0] data);
    exp_t e;
    e.kind = kind;
    e.addr = 12'(addr);
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clock);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Sends frame_words as a frame. chk_flip != 0 corrupts the checksum; a stall of
  // stall_len idle cycles follows byte index stall_at (0 = MAGIC).
  task automatic send_frame(input logic [7:0] chk_flip, input int stall_at, input int stall_len,
                            input int max_gap);
    logic [7:0] bytes[$];
    logic [7:0] x;
    int         n;
    bit         timed_out;
    n = frame_words.size();
    bytes.push_back(MAG);
    bytes.push_back(8'(n));
    bytes.push_back(8'(n >> 8));
    foreach (frame_words[i]) for (int k = 0; k < 4; k++) bytes.push_back(frame_words[i][8*k +: 8]);
    x = 8'h00;
    for (int i = 1; i < bytes.size(); i++) x ^= bytes[i];
    bytes.push_back(x ^ chk_flip);

    timed_out = (stall_at >= 0) && (stall_len >= int'(TB_TIMEOUT)) &&
                (stall_at < bytes.size() - 1);
    foreach (frame_words[i])
      if (!timed_out || (4 * i + 6 <= stall_at)) push(KWrite, i, frame_words[i]);
    push((!timed_out && chk_flip == 8'h00) ? KDone : KError, 0, 32'h0);

    for (int i = 0; i < bytes.size(); i++) begin
      if (i > 0 && (i - 1) != stall_at && max_gap > 0) idle($urandom_range(0, max_gap));
      send_byte(bytes[i]);
      if (i == 0) begin
        @(negedge clock);
        check("busy after MAGIC", busy, 1);
        check("core_reset after MAGIC", core_reset, 1);
        check("done cleared by MAGIC", done, 0);
        check("error cleared by MAGIC", error, 0);
      end
      if (i == stall_at) begin
        idle(stall_len);
        if (timed_out) break;
      end
    end
    idle(2);
  endtask

  task automatic check_reset_vals();
    check("rst isp_write", isp_write, 0);
    check("rst isp_address", isp_address, 0);
    check("rst isp_data", isp_data, 0);
    check("rst core_reset", core_reset, 1);
    check("rst start", start, 0);
    check("rst prog_address", prog_address, PROG);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst error", error, 0);
  endtask

  // Monitor: every DUT event pops the next expectation in order.
  always @(negedge clock) begin
    if (mon_en) begin
      if (isp_write) begin
        check("write expected", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("write kind", mon_e.kind, KWrite);
          check("write addr", isp_address, mon_e.addr);
          check("write data", isp_data, mon_e.data);
          check("core held during write", core_reset, 1);
        end
      end
      if (start) begin
        check("start single cycle", start_prev, 0);
        check("start expected", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("start kind", mon_e.kind, KDone);
          check("done with start", done, 1);
          check("core_reset released", core_reset, 0);
          check("busy low at start", busy, 0);
          check("prog_address", prog_address, PROG);
        end
      end
      if (error && !error_prev) begin
        check("error expected", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("error kind", mon_e.kind, KError);
          check("busy low on error", busy, 0);
          check("core held on error", core_reset, 1);
        end
      end
    end
    start_prev <= start;
    error_prev <= error;
  end

  initial begin
    logic [7:0] g;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle(3);
    reset = 1'b0;
    @(negedge clock);
    check_reset_vals();
    mon_en = 1'b1;

    // Basic two-word load, then corrupted checksum.
    frame_words = '{32'h00C58533, 32'h00000013};
    send_frame(8'h00, -1, 0, 0);
    send_frame(8'h01, -1, 0, 0);

    // Garbage before MAGIC, then a zero-length frame.
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12);
    send_frame(8'h00, -1, 0, 0);
    frame_words = {};
    send_frame(8'h00, -1, 0, 0);

    // Length overflow (N = 4097), then a good frame clears error.
    push(KError, 0, 32'h0);
    send_byte(MAG); send_byte(8'h01); send_byte(8'h10);
    idle(2);
    frame_words = '{32'h00C58533, 32'h00000013};
    send_frame(8'h00, -1, 0, 1);

    // Timeout after the 2nd data byte, then one cycle short of it.
    send_frame(8'h00, 4, TB_TIMEOUT, 0);
    send_frame(8'h00, 4, TB_TIMEOUT - 1, 0);

    // Reset after 3 data bytes, then a fresh frame starts at address 0.
    send_byte(MAG); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h33); send_byte(8'h85); send_byte(8'hC5);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    @(negedge clock);
    check_reset_vals();
    send_frame(8'h00, -1, 0, 0);

    // Largest legal frame: address must reach 2**AB-1.
    frame_words = {};
    for (int i = 0; i < (1 << AB); i++) frame_words.push_back($urandom);
    send_frame(8'h00, -1, 0, 0);

    // Random frames with gaps, MAGIC-valued data, bad checksums and stalls.
    for (int f = 0; f < 40; f++) begin
      int n, sat, slen;
      n = $urandom_range(0, 6);
      frame_words = {};
      for (int i = 0; i < n; i++) begin
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 3) == 0) w[8*$urandom_range(0, 3) +: 8] = MAG;
        frame_words.push_back(w);
      end
      repeat ($urandom_range(0, 2)) begin
        g = 8'($urandom);
        if (g == MAG) g = 8'h00;
        send_byte(g);
      end
      sat  = -1;
      slen = 0;
      if ($urandom_range(0, 4) == 0) begin
        sat  = $urandom_range(0, 4 * n + 2);
        slen = ($urandom_range(0, 1) == 0) ? TB_TIMEOUT : TB_TIMEOUT - 1;
      end
      send_frame(($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00, sat, slen, 3);
    end

    idle(5);
    check("expectations drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
